core_run_controller: RTL

- Run controller between the testbench/host start pulse and the `Processor_Dynamic` core array.
- Latches a per-core enable mask and issues a one-cycle `core_start` pulse to the enabled cores.
- Collects each core's `endop_signal` into a sticky completion mask and counts run cycles.
- Raises `done` when every enabled core has finished, or flags a timeout; the bench then stops on `done` rather than polling `endop_signal[0]` alone.

---
 rtl/proc_ctrl_pkg.sv | 17 +
 rtl/sticky_mask.sv | 39 +++
 rtl/core_run_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor run-control slice: default core count
// and the run controller state encoding.
package proc_ctrl_pkg;

  // Number of cores in Processor_Dynamic; the testbench uses the same value.
  localparam int CORE_COUNT = 3;

  // Run controller states. The 2-bit encodings are fixed so that waveform
  // viewers and older scripts decode them the same way.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } run_state_e;

endpackage

// File: rtl/sticky_mask.sv
// Per-bit sticky flag register. Bits can only be set where the enable mask
// allows it, and once set they stay set until a clear is requested.
module sticky_mask #(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_en,
  input  logic [width-1:0] set,
  input  logic [width-1:0] enable,
  output logic [width-1:0] mask
);

  logic [width-1:0] mask_q;
  logic [width-1:0] mask_d;

  // Clear has priority over set so a new run always starts from an empty mask.
  always_comb begin
    mask_d = mask_q;
    if (clear) begin
      mask_d = '0;
    end else if (set_en) begin
      mask_d = mask_q | (set & enable);
    end
  end

  // Flag storage, wiped by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask = mask_q;

endmodule

// File: rtl/core_run_controller.sv
// Run controller for the Processor_Dynamic core array: accepts a start
// request with a core enable mask, pulses core_start to the enabled cores,
// gathers their end-of-operation flags and reports done or a timeout.
module core_run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int core_count     = CORE_COUNT,
  parameter int cnt_width      = 16,
  parameter int timeout_cycles = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [core_count-1:0] core_enable,
  input  logic [core_count-1:0] endop_signal,
  output logic [core_count-1:0] core_start,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic [core_count-1:0] done_mask,
  output logic [cnt_width-1:0]  cycle_count
);

  localparam logic [cnt_width-1:0] COUNT_MAX    = '1;
  localparam logic [cnt_width-1:0] TIMEOUT_LAST = cnt_width'(timeout_cycles - 1);

  run_state_e            state_q, state_d;
  logic [core_count-1:0] en_q, en_d;
  logic [core_count-1:0] core_start_q, core_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timed_out_q, timed_out_d;
  logic [cnt_width-1:0]  count_q, count_d;

  logic                  accept;
  logic                  in_run;
  logic                  complete;
  logic                  timeout_hit;
  logic [core_count-1:0] mask_w;

  // A start only counts in IDLE and only if at least one core would launch.
  assign accept = (state_q == IDLE) && start && (core_enable != '0);
  assign in_run = (state_q == RUN);

  // Completion looks at this cycle's endop as well, so the run ends on the
  // same edge the last enabled core reports in.
  assign complete = in_run && ((mask_w | (endop_signal & en_q)) == en_q);

  // Timeout fires on the edge that would make the count reach the limit;
  // a simultaneous completion takes precedence.
  assign timeout_hit = in_run && (timeout_cycles != 0) &&
                       (count_q == TIMEOUT_LAST) && !complete;

  // Completion flags: cleared on an accepted start, collected only in RUN.
  sticky_mask #(
    .width (core_count)
  ) u_done_mask (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .set_en (in_run),
    .set    (endop_signal),
    .enable (en_q),
    .mask   (mask_w)
  );

  // Next-state logic for the FSM, run counter and registered outputs.
  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    core_start_d = '0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timed_out_d  = timed_out_q;
    count_d      = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = LAUNCH;
          en_d         = core_enable;
          core_start_d = core_enable;
          busy_d       = 1'b1;
          timed_out_d  = 1'b0;
          count_d      = '0;
        end
      end
      LAUNCH: begin
        state_d = RUN;
      end
      RUN: begin
        if (count_q != COUNT_MAX) begin
          count_d = count_q + 1'b1;
        end
        if (complete || timeout_hit) begin
          state_d     = FINISH;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          timed_out_d = timeout_hit;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops everything, core_start included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      en_q         <= '0;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      count_q      <= count_d;
    end
  end

  assign core_start  = core_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign done_mask   = mask_w;
  assign cycle_count = count_q;

endmodule
